// File: rtl/vdc_bus_master.sv
// HuC6270 VDC register-port bus initiator: register commands -> CS_n/RD_n/WR_n byte cycles, plus IRQ_n synchroniser.
// Latency (BUSY_n high): (2+STROBE_CYCLES) clocks per byte + 1; BUSY_n low stretches the strobe, timeout aborts. Optional VDC_ADDR_CACHE_EN skips a repeated A0 select.
// Backpressure: cmd_ready is low from handshake until the response pulse; rsp has no ready (one-cycle pulse).
module vdc_bus_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned BUSY_TIMEOUT  = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        CS_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic [1:0]  A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    input  logic        BUSY_n,
    input  logic        IRQ_n,
    output logic        irq
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAITB, S_HOLD, S_DONE} state_t;

    localparam logic [7:0] STB_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    // Byte index 0 = A0 select/status, 1 = A2 (LSB), 2 = A3 (MSB).
    function automatic logic byte_is_rd(input logic [1:0] op, input logic [1:0] idx);
        return (op == 2'd0) || (op == 2'd3) || ((op == 2'd2) && (idx != 2'd0));
    endfunction

    function automatic logic [1:0] byte_addr(input logic [1:0] idx);
        return (idx == 2'd0) ? 2'd0 : ((idx == 2'd1) ? 2'd2 : 2'd3);
    endfunction

    function automatic logic [7:0] byte_dat(input logic [1:0] op, input logic [4:0] rg,
                                            input logic [15:0] wd, input logic [1:0] idx);
        logic [7:0] d;
        d = 8'h00;
        if (!byte_is_rd(op, idx)) begin
            case (idx)
                2'd0:    d = {3'b000, rg};
                2'd1:    d = wd[7:0];
                default: d = wd[15:8];
            endcase
        end
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdacc_q, rdacc_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic        irq_s1_q, irq_s2_q;

    logic        cur_rd, active, strobe, cache_hit;
    logic [1:0]  last_idx;
    logic [15:0] rdacc_cap;

`ifdef VDC_ADDR_CACHE_EN
    logic        cache_vld_q, cache_vld_d;
    logic [4:0]  cache_reg_q, cache_reg_d;
    assign cache_hit = ((cmd_op == 2'd1) || (cmd_op == 2'd2)) && cache_vld_q && (cache_reg_q == cmd_reg);
`else
    assign cache_hit = 1'b0;
`endif

    assign cur_rd   = byte_is_rd(op_q, idx_q);
    assign last_idx = ((op_q == 2'd1) || (op_q == 2'd2)) ? 2'd2 : 2'd0;
    assign active   = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                      (state_q == S_WAITB) || (state_q == S_HOLD);
    assign strobe   = (state_q == S_STROBE) || (state_q == S_WAITB);

    // Strobes decode straight from the async-reset state so reset releases the bus at once.
    assign cmd_ready = (state_q == S_IDLE);
    assign CS_n      = !active;
    assign RD_n      = !(strobe && cur_rd);
    assign WR_n      = !(strobe && !cur_rd);
    assign D_oe      = active && !cur_rd;
    assign A         = a_q;
    assign D_out     = dout_q;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign irq       = !irq_s2_q;

    always_comb begin
        rdacc_cap = rdacc_q;
        if (cur_rd) begin
            if (idx_q == 2'd2) rdacc_cap[15:8] = D_in;
            else               rdacc_cap[7:0]  = D_in;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        reg_d   = reg_q;
        wd_d    = wd_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdacc_d = rdacc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        a_d     = a_q;
        dout_d  = dout_q;
`ifdef VDC_ADDR_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_reg_d = cache_reg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    reg_d   = cmd_reg;
                    wd_d    = cmd_wdata;
                    idx_d   = cache_hit ? 2'd1 : 2'd0;
                    rdacc_d = 16'h0000;
                    err_d   = 1'b0;
                    a_d     = byte_addr(idx_d);
                    dout_d  = byte_dat(cmd_op, cmd_reg, cmd_wdata, idx_d);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = 8'd0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == STB_LAST) begin
                    cnt_d = 8'd0;
                    if (BUSY_n) begin
                        rdacc_d = rdacc_cap;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAITB;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAITB: begin
                if (BUSY_n) begin
                    rdacc_d = rdacc_cap;
                    state_d = S_HOLD;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 16'h0000;
`ifdef VDC_ADDR_CACHE_EN
                    cache_vld_d = 1'b0;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
`ifdef VDC_ADDR_CACHE_EN
                if ((idx_q == 2'd0) && (last_idx == 2'd2)) begin
                    cache_vld_d = 1'b1;
                    cache_reg_d = reg_q;
                end
`endif
                if (idx_q == last_idx) begin
                    rdata_d = rdacc_q;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    a_d     = byte_addr(idx_d);
                    dout_d  = byte_dat(op_q, reg_q, wd_q, idx_d);
                    state_d = S_SETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'd0;
            reg_q    <= 5'd0;
            wd_q     <= 16'h0000;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            rdacc_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
            a_q      <= 2'd0;
            dout_q   <= 8'h00;
            irq_s1_q <= 1'b1;
            irq_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            reg_q    <= reg_d;
            wd_q     <= wd_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdacc_q  <= rdacc_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            a_q      <= a_d;
            dout_q   <= dout_d;
            irq_s1_q <= IRQ_n;
            irq_s2_q <= irq_s1_q;
        end
    end

`ifdef VDC_ADDR_CACHE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld_q <= 1'b0;
            cache_reg_q <= 5'd0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_reg_q <= cache_reg_d;
        end
    end
`endif
endmodule
